// File: rtl/count_uart_reporter.sv
// Sends each new 4-bit count value as one ASCII hex digit over 8N1 UART,
// optionally followed by CR LF. Count changes made while a message is in flight collapse to the latest value.
module count_uart_reporter #(
  parameter int CLK_HZ       = 12000000,
  parameter int BAUD         = 115200,
  parameter int SEND_NEWLINE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] count,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int TIMER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [1:0] LAST_CHAR = (SEND_NEWLINE != 0) ? 2'd2 : 2'd0;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state, state_nx;
  logic [3:0]         last_sent, last_sent_nx;
  logic [3:0]         snap, snap_nx;
  logic [1:0]         char_idx, char_idx_nx;
  logic [2:0]         bit_idx, bit_idx_nx;
  logic [TIMER_W-1:0] timer, timer_nx;
  logic               tx_nx, busy_nx, frame_done_nx;
  logic               bit_end;
  logic [7:0]         cur_char;

  function automatic logic [7:0] hex_ascii(input logic [3:0] v);
    if (v < 4'd10) return 8'h30 + {4'h0, v};
    else           return 8'h37 + {4'h0, v};  // 0x37 + 10 = 'A'
  endfunction

  function automatic logic [7:0] char_at(input logic [1:0] idx, input logic [3:0] v);
    case (idx)
      2'd1:    return 8'h0D;
      2'd2:    return 8'h0A;
      default: return hex_ascii(v);
    endcase
  endfunction

  assign bit_end  = (timer == TIMER_LAST);
  assign cur_char = char_at(char_idx, snap);

  always_comb begin
    state_nx      = state;
    last_sent_nx  = last_sent;
    snap_nx       = snap;
    char_idx_nx   = char_idx;
    bit_idx_nx    = bit_idx;
    tx_nx         = tx;
    busy_nx       = busy;
    frame_done_nx = 1'b0;
    timer_nx      = bit_end ? '0 : timer + 1'b1;
    case (state)
      IDLE: begin
        timer_nx = '0;
        tx_nx    = 1'b1;
        busy_nx  = 1'b0;
        // The frame_done cycle is always spent idle before a new change is accepted.
        if (!frame_done && (count != last_sent)) begin
          state_nx     = START;
          snap_nx      = count;
          last_sent_nx = count;
          char_idx_nx  = 2'd0;
          tx_nx        = 1'b0;
          busy_nx      = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_nx   = DATA;
          bit_idx_nx = 3'd0;
          tx_nx      = cur_char[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state_nx = STOP;
            tx_nx    = 1'b1;
          end else begin
            bit_idx_nx = bit_idx + 3'd1;
            tx_nx      = cur_char[bit_idx + 3'd1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (char_idx != LAST_CHAR) begin
            state_nx    = START;
            char_idx_nx = char_idx + 2'd1;
            tx_nx       = 1'b0;
          end else begin
            state_nx      = IDLE;
            busy_nx       = 1'b0;
            frame_done_nx = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control registers: cleared asynchronously so a reset aborts a frame at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_sent  <= 4'h0;
      timer      <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      last_sent  <= last_sent_nx;
      timer      <= timer_nx;
      tx         <= tx_nx;
      busy       <= busy_nx;
      frame_done <= frame_done_nx;
    end
  end

  // Datapath registers: only read while a message is active.
  always_ff @(posedge clk) begin
    snap     <= snap_nx;
    char_idx <= char_idx_nx;
    bit_idx  <= bit_idx_nx;
  end

endmodule
